iram_program_loader: RTL and testbench

Sequencing controller for the 1024×32 instruction RAM. On command it copies a block of program words from the HD (secondary storage) into a contiguous range of instruction RAM, one word at a time over a request/valid read handshake. While copying, it stalls the CPU and takes ownership of the RAM address port; otherwise it passes the CPU fetch address straight through. It sits between the CPU fetch stage, the HD controller and the instruction RAM, and is the block the OS-level context-switch code uses to swap programs in.

---
 rtl/iram_loader_pkg.sv | 13 +
 rtl/hd_read_timer.sv | 21 ++
 rtl/iram_program_loader.sv | 126 ++++++++++++
 tb/tb_iram_program_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: shared types and defaults for the instruction RAM program loader.
// Holds the loader state enum, error codes and the address/data widths
// shared with the instruction RAM and the HD controller.
package iram_loader_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_HD_ADDR_W = 12;
  localparam int DEF_TIMEOUT = 64;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, FAIL} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/hd_read_timer.sv
// hd_read_timer: wait counter for an HD read, flags when LIMIT cycles have elapsed.
// Ports: clk, rst_n (async active-low), load (restart at 1 next cycle),
//        en (count while waiting), expired (count has reached LIMIT).
module hd_read_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT);
  // Saturates at LIMIT so a long-stalled client never sees the flag drop.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(1);
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/iram_program_loader.sv
// iram_program_loader: copies a block of HD words into instruction RAM, stalling the CPU meanwhile.
// Ports: clk, rst_n (async active-low); load_start/hd_base/ram_base/load_len command;
//        hd_read_req/hd_read_addr/hd_read_valid/hd_read_data HD read handshake;
//        iram_write_en/iram_address/iram_write_data RAM port (cpu_pc passes through when idle);
//        cpu_stall, load_busy, load_done (one-cycle pulse), load_error (sticky code).
module iram_program_loader
  import iram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int HD_ADDR_W = DEF_HD_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [HD_ADDR_W-1:0] hd_base,
  input  logic [ADDR_W-1:0]    ram_base,
  input  logic [ADDR_W:0]      load_len,
  output logic                 hd_read_req,
  output logic [HD_ADDR_W-1:0] hd_read_addr,
  input  logic                 hd_read_valid,
  input  logic [DATA_W-1:0]    hd_read_data,
  output logic                 iram_write_en,
  output logic [ADDR_W-1:0]    iram_address,
  output logic [DATA_W-1:0]    iram_write_data,
  input  logic [ADDR_W-1:0]    cpu_pc,
  output logic                 cpu_stall,
  output logic                 load_busy,
  output logic                 load_done,
  output logic [1:0]           load_error
);
  localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};
  state_t state;
  logic [HD_ADDR_W-1:0] hd_base_q;
  logic [ADDR_W-1:0] ram_base_q;
  logic [ADDR_W:0] len_q, count, count_nx;
  logic [ADDR_W+1:0] range_end;
  logic range_bad, hold, timeout;
  assign range_end = {2'b00, ram_base} + {1'b0, load_len};
  assign range_bad = range_end > DEPTH;
  assign count_nx = count + 1'b1;
  assign cpu_stall = load_busy;
  assign iram_address = state == IDLE ? cpu_pc : ram_base_q + count[ADDR_W-1:0];
  hd_read_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == READ),
    .en(state == WAIT),
    .expired(timeout)
  );
  // hold marks a command decided straight from IDLE (empty or out-of-range);
  // it keeps DONE/FAIL for a second cycle so the outcome is reported one cycle later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hd_base_q <= '0;
      ram_base_q <= '0;
      len_q <= '0;
      count <= '0;
      hold <= 1'b0;
      hd_read_req <= 1'b0;
      hd_read_addr <= '0;
      iram_write_en <= 1'b0;
      iram_write_data <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_error <= ERR_NONE;
    end else begin
      hd_read_req <= 1'b0;
      iram_write_en <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          hd_base_q <= hd_base;
          ram_base_q <= ram_base;
          len_q <= load_len;
          count <= '0;
          load_busy <= 1'b1;
          hold <= load_len == '0 || range_bad;
          load_error <= ERR_NONE;
          if (load_len == '0) state <= DONE;
          else if (range_bad) begin
            state <= FAIL;
            load_error <= ERR_RANGE;
          end else begin
            state <= READ;
            hd_read_req <= 1'b1;
            hd_read_addr <= hd_base;
          end
        end
        READ: state <= WAIT;
        WAIT: if (hd_read_valid) begin
          iram_write_data <= hd_read_data;
          iram_write_en <= 1'b1;
          state <= WRITE;
        end else if (timeout) begin
          state <= FAIL;
          load_error <= ERR_TIMEOUT;
        end
        WRITE: begin
          count <= count_nx;
          if (count_nx == len_q) begin
            state <= DONE;
            load_done <= 1'b1;
          end else begin
            state <= READ;
            hd_read_req <= 1'b1;
            hd_read_addr <= hd_base_q + HD_ADDR_W'(count_nx);
          end
        end
        DONE: begin
          hold <= 1'b0;
          load_done <= hold;
          load_busy <= hold;
          state <= hold ? DONE : IDLE;
        end
        FAIL: begin
          hold <= 1'b0;
          load_busy <= hold;
          state <= hold ? FAIL : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iram_program_loader.sv
// tb_iram_program_loader: directed self-checking bench for the instruction RAM program loader.
module tb_iram_program_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic [11:0] hd_base = '0;
  logic [9:0] ram_base = '0;
  logic [10:0] load_len = '0;
  logic hd_read_req, hd_read_valid;
  logic [11:0] hd_read_addr;
  logic [31:0] hd_read_data;
  logic iram_write_en;
  logic [9:0] iram_address;
  logic [31:0] iram_write_data;
  logic [9:0] cpu_pc = 10'h155;
  logic cpu_stall, load_busy, load_done;
  logic [1:0] load_error;
  int vectors = 0;
  int errors = 0;
  int wr_cnt = 0;
  int req_cnt = 0;
  logic [31:0] ram [1024];
  bit hd_mute = 0;
  bit hd_rand = 0;

  iram_program_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .hd_base(hd_base),
    .ram_base(ram_base), .load_len(load_len), .hd_read_req(hd_read_req),
    .hd_read_addr(hd_read_addr), .hd_read_valid(hd_read_valid), .hd_read_data(hd_read_data),
    .iram_write_en(iram_write_en), .iram_address(iram_address), .iram_write_data(iram_write_data),
    .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hd_word(input logic [11:0] a);
    return {20'h0, a} - 32'hF6;
  endfunction

  always @(posedge clk) begin
    if (rst_n && iram_write_en) begin
      ram[iram_address] <= iram_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rst_n && hd_read_req) req_cnt <= req_cnt + 1;
  end

  initial begin
    hd_read_valid = 1'b0;
    hd_read_data = '0;
    forever begin
      @(posedge clk);
      if (rst_n && hd_read_req && !hd_mute) begin
        automatic logic [11:0] a = hd_read_addr;
        automatic int d = hd_rand ? int'($urandom_range(0, 5)) : 0;
        #1;
        repeat (d) begin
          @(posedge clk);
          #1;
        end
        hd_read_valid = 1'b1;
        hd_read_data = hd_word(a);
        @(posedge clk);
        #1;
        hd_read_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [11:0] hb, input logic [9:0] rb, input logic [10:0] len);
    @(negedge clk);
    hd_base = hb;
    ram_base = rb;
    load_len = len;
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic watch(input int n, output logic [31:0] stall_m, output logic [31:0] done_m);
    stall_m = '0;
    done_m = '0;
    for (int i = 1; i <= n; i++) begin
      stall_m[i] = cpu_stall;
      done_m[i] = load_done;
      step();
    end
  endtask

  task automatic wait_done(input int lim, output logic seen);
    seen = 1'b0;
    for (int t = 0; t < lim && !seen; t++) begin
      if (load_done) seen = 1'b1;
      step();
    end
  endtask

  initial begin
    logic [31:0] sm, dm;
    logic seen;
    int w0, r0, err_at, idle_at;
    #12;
    chk("rst_req", hd_read_req, 0);
    chk("rst_wen", iram_write_en, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    chk("rst_haddr", hd_read_addr, 0);
    chk("rst_wdata", iram_write_data, 0);
    chk("rst_addr", iram_address, 10'h155);
    @(negedge clk);
    rst_n = 1'b1;

    w0 = wr_cnt; r0 = req_cnt;
    start(12'h100, 10'd0, 11'd3);
    chk("t1_req", hd_read_req, 1);
    chk("t1_haddr", hd_read_addr, 12'h100);
    chk("t1_busy", load_busy, 1);
    watch(12, sm, dm);
    chk("t1_stall", sm, 32'h7FE);
    chk("t1_done", dm, 32'h400);
    chk("t1_ram0", ram[0], 32'hA);
    chk("t1_ram1", ram[1], 32'hB);
    chk("t1_ram2", ram[2], 32'hC);
    chk("t1_wrs", wr_cnt - w0, 3);
    chk("t1_reqs", req_cnt - r0, 3);
    chk("t1_err", load_error, 0);
    chk("t1_pc", iram_address, 10'h155);

    w0 = wr_cnt; r0 = req_cnt;
    start(12'h020, 10'd5, 11'd0);
    watch(5, sm, dm);
    chk("t2_stall", sm, 32'h6);
    chk("t2_done", dm, 32'h4);
    chk("t2_wrs", wr_cnt - w0, 0);
    chk("t2_reqs", req_cnt - r0, 0);
    chk("t2_err", load_error, 0);

    w0 = wr_cnt; r0 = req_cnt;
    start(12'h000, 10'd1000, 11'd30);
    chk("t3_err_now", load_error, 1);
    watch(5, sm, dm);
    chk("t3_stall", sm, 32'h6);
    chk("t3_done", dm, 32'h0);
    chk("t3_reqs", req_cnt - r0, 0);
    chk("t3_wrs", wr_cnt - w0, 0);
    chk("t3_err", load_error, 1);

    w0 = wr_cnt;
    start(12'hFFE, 10'd1020, 11'd4);
    chk("t4_err_clr", load_error, 0);
    chk("t4_req", hd_read_req, 1);
    wait_done(40, seen);
    chk("t4_done", seen, 1);
    chk("t4_ram1020", ram[1020], hd_word(12'hFFE));
    chk("t4_ram1023", ram[1023], hd_word(12'h001));
    chk("t4_wrs", wr_cnt - w0, 4);

    hd_mute = 1;
    err_at = 0; idle_at = 0;
    start(12'h000, 10'd0, 11'd1);
    for (int i = 1; i <= 80; i++) begin
      if (err_at == 0 && load_error == 2'd2) err_at = i;
      if (i > 1 && idle_at == 0 && !cpu_stall) idle_at = i;
      step();
    end
    hd_mute = 0;
    chk("t5_err_at", err_at, 66);
    chk("t5_idle_at", idle_at, 67);
    chk("t5_busy", load_busy, 0);

    hd_rand = 1;
    w0 = wr_cnt; r0 = req_cnt;
    start(12'h200, 10'd100, 11'd4);
    step();
    step();
    start(12'h300, 10'd200, 11'd2);
    wait_done(200, seen);
    chk("t6_done", seen, 1);
    repeat (4) step();
    chk("t6_busy", load_busy, 0);
    chk("t6_reqs", req_cnt - r0, 4);
    chk("t6_wrs", wr_cnt - w0, 4);
    chk("t6_ram100", ram[100], hd_word(12'h200));
    chk("t6_ram103", ram[103], hd_word(12'h203));
    chk("t6_err", load_error, 0);
    hd_rand = 0;

    start(12'h100, 10'd10, 11'd3);
    repeat (4) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", load_busy, 0);
    chk("t7_stall", cpu_stall, 0);
    chk("t7_req", hd_read_req, 0);
    chk("t7_wen", iram_write_en, 0);
    chk("t7_wdata", iram_write_data, 0);
    chk("t7_haddr", hd_read_addr, 0);
    chk("t7_addr", iram_address, 10'h155);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    start(12'h180, 10'd50, 11'd2);
    wait_done(40, seen);
    chk("t7_done", seen, 1);
    chk("t7_ram50", ram[50], hd_word(12'h180));
    chk("t7_ram51", ram[51], hd_word(12'h181));
    chk("t7_wrs", wr_cnt - w0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
